// File: rtl/i2c_pkg.sv
// Shared I2C constants used as parameter defaults across the I2C blocks.
package i2c_pkg;
   localparam int I2C_DATA_WIDTH      = 8;
   localparam int I2C_FIFO_ADDR_WIDTH = 4;
endpackage

// File: rtl/i2c_fifo_mem.sv
// Transmit FIFO storage: synchronous write, asynchronous read, synchronous clear of all entries.
module i2c_fifo_mem
   import i2c_pkg::*;
#(
   parameter int DATA_WIDTH = I2C_DATA_WIDTH,
   parameter int ADDR_WIDTH = I2C_FIFO_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_clr,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/i2c_trans_fifo.sv
// First-word-fall-through transmit FIFO between host writes and the I2C master FSM.
// Optional sticky overflow/underflow flags when I2C_TRANS_FIFO_STATUS_EN is defined.
module i2c_trans_fifo
   import i2c_pkg::*;
#(
   parameter int DATA_WIDTH = I2C_DATA_WIDTH,
   parameter int ADDR_WIDTH = I2C_FIFO_ADDR_WIDTH
) (
   input  logic                  i2c_core_clock_i,
   input  logic                  reset_bit_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  trans_fifo_empty_o,
   output logic                  trans_fifo_full_o,
   output logic [ADDR_WIDTH:0]   count_o
`ifdef I2C_TRANS_FIFO_STATUS_EN
   ,
   input  logic                  clear_status_i,
   output logic                  overflow_o,
   output logic                  underflow_o
`endif
);
   localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr, r_count;
   logic                r_empty, r_full;
   logic [ADDR_WIDTH:0] w_wr_ptr_n, w_rd_ptr_n, w_count_n;
   logic                w_wr_ok, w_rd_ok;

   // A write while full is only accepted when a pop frees the head slot in the same cycle.
   assign w_wr_ok = wr_en_i & (~r_full | rd_en_i);
   assign w_rd_ok = rd_en_i & ~r_empty;

   always_comb begin
      w_wr_ptr_n = r_wr_ptr;
      w_rd_ptr_n = r_rd_ptr;
      w_count_n  = r_count;
      if (w_wr_ok) w_wr_ptr_n = r_wr_ptr + ONE;
      if (w_rd_ok) w_rd_ptr_n = r_rd_ptr + ONE;
      case ({w_wr_ok, w_rd_ok})
         2'b10:   w_count_n = r_count + ONE;
         2'b01:   w_count_n = r_count - ONE;
         default: w_count_n = r_count;
      endcase
   end

   always_ff @(posedge i2c_core_clock_i) begin
      if (reset_bit_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_n;
         r_rd_ptr <= w_rd_ptr_n;
         r_count  <= w_count_n;
         r_empty  <= (w_wr_ptr_n == w_rd_ptr_n);
         r_full   <= (w_wr_ptr_n[ADDR_WIDTH] != w_rd_ptr_n[ADDR_WIDTH]) &&
                     (w_wr_ptr_n[ADDR_WIDTH-1:0] == w_rd_ptr_n[ADDR_WIDTH-1:0]);
      end
   end

   i2c_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .i_clk   (i2c_core_clock_i),
      .i_clr   (reset_bit_i),
      .i_we    (w_wr_ok),
      .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
      .i_wdata (wr_data_i),
      .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rdata (data_o)
   );

   assign trans_fifo_empty_o = r_empty;
   assign trans_fifo_full_o  = r_full;
   assign count_o            = r_count;

`ifdef I2C_TRANS_FIFO_STATUS_EN
   logic r_overflow, r_underflow;

   // New event beats clear_status_i in the same cycle.
   always_ff @(posedge i2c_core_clock_i) begin
      if (reset_bit_i) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en_i & r_full & ~rd_en_i) r_overflow <= 1'b1;
         else if (clear_status_i)         r_overflow <= 1'b0;
         if (rd_en_i & r_empty)           r_underflow <= 1'b1;
         else if (clear_status_i)         r_underflow <= 1'b0;
      end
   end

   assign overflow_o  = r_overflow;
   assign underflow_o = r_underflow;
`endif
endmodule

// File: doc/i2c_trans_fifo.md
I2C_TRANS_FIFO -- requirements
Module: i2c_trans_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width of each entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: log2 of depth, giving 16 entries.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-004 i2c_core_clock_i  input  1  core clock; all state changes on its rising edge.
REQ-005 reset_bit_i  input  1  reset from the cmd register.
REQ-006 wr_en_i  input  1  host write strobe; pushes wr_data_i.
REQ-007 wr_data_i  input  DATA_WIDTH  byte from the host.
REQ-008 rd_en_i  input  1  pop strobe from the master FSM when a data byte has been loaded.
REQ-009 data_o  output  DATA_WIDTH  head entry; drives the master data_i.
REQ-010 trans_fifo_empty_o  output  1  drives the master trans_fifo_empty_i.
REQ-011 trans_fifo_full_o  output  1  no free entry.
REQ-012 count_o  output  ADDR_WIDTH+1  number of stored entries, 0..16.

Function
REQ-013 SHALL be first-word-fall-through: data_o equals the entry at the read pointer in the same cycle it becomes valid, with no read latency.
REQ-014 SHALL hold data_o stable while rd_en_i is low.
REQ-015 Write when not full: store wr_data_i at the write pointer; write pointer +1 and count +1 on the next edge.
REQ-016 Read when not empty: read pointer +1 and count -1 on the next edge.
REQ-017 Write while full and rd_en_i low: write dropped; no state change.
REQ-018 Read while empty: read ignored; no state change.
REQ-019 Simultaneous read and write while full: both performed; count stays at 16; the new byte lands in the freed slot.
REQ-020 Simultaneous read and write while empty: write performed, read ignored; count becomes 1; data_o shows the new byte the next cycle.
REQ-021 Simultaneous read and write otherwise: both performed; count unchanged.
REQ-022 Pointers SHALL be ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
REQ-023 Empty SHALL be decoded as pointers fully equal; full as the MSBs differing with the remaining bits equal.
REQ-024 trans_fifo_empty_o, trans_fifo_full_o and count_o SHALL be registered and reflect the state after the last edge.

Reset
REQ-025 While reset_bit_i is high at an edge: pointers = 0, count_o = 0, trans_fifo_empty_o = 1, trans_fifo_full_o = 0, all storage cleared, data_o = 0.
REQ-026 Reset SHALL override wr_en_i and rd_en_i in the same cycle; a reset mid-operation discards all entries.

Configuration
REQ-027 Macro I2C_TRANS_FIFO_STATUS_EN, when defined, SHALL add output ports overflow_o and underflow_o and input port clear_status_i.
REQ-028 With the macro, overflow_o SHALL set one cycle after a write is dropped while full.
REQ-029 With the macro, underflow_o SHALL set one cycle after a read is ignored while empty.
REQ-030 With the macro, both flags SHALL be sticky and cleared by reset or clear_status_i; a new event in the same cycle as clear_status_i wins.
REQ-031 Without the macro, those ports and flag logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared package i2c_pkg SHALL hold the I2C_DATA_WIDTH (8) and I2C_FIFO_ADDR_WIDTH (4) constants used as parameter defaults.
REQ-033 Storage SHALL be a sub-module i2c_fifo_mem: synchronous write, asynchronous read, synchronous clear.
REQ-034 Pointer, flag and count logic SHALL live in i2c_trans_fifo.

Verification
REQ-035 Reset, then idle: count_o = 0, trans_fifo_empty_o = 1, trans_fifo_full_o = 0, data_o = 0x00.
REQ-036 Write 0xA5, then 0x3C: the cycle after the first write data_o = 0xA5; one pop gives data_o = 0x3C and count_o = 1.
REQ-037 Write 16 bytes 0x00..0x0F, then write 0xFF: trans_fifo_full_o = 1, count_o = 16, 0xFF dropped; 16 pops return 0x00..0x0F in order, then empty = 1 (overflow_o = 1 with macro).
REQ-038 Full FIFO, simultaneous write 0x77 and pop: count_o stays 16; after 15 further pops data_o = 0x77.
REQ-039 Interleave 40 pushes and pops across pointer wrap: output sequence matches a reference queue, no flag glitches; pop on empty leaves count 0 (underflow_o = 1 with macro).
REQ-040 Assert reset_bit_i with 5 entries stored and wr_en_i high: the next cycle count_o = 0, empty = 1, data_o = 0x00.
